// File: rtl/mult_pkg.sv
// Shared state encoding and adder function codes for the add-shift multiplier control.
package mult_pkg;

   typedef logic [2:0] mult_state_t;

   localparam mult_state_t IDLE  = 3'd0;
   localparam mult_state_t CLEAR = 3'd1;
   localparam mult_state_t ADD   = 3'd2;
   localparam mult_state_t SHIFT = 3'd3;
   localparam mult_state_t HOLD  = 3'd4;

   localparam logic FN_ADD = 1'b0;
   localparam logic FN_SUB = 1'b1;

   function automatic int unsigned cnt_width(input int unsigned width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/mult_step_counter.sv
// Add/shift step counter; flags the final step so the FSM never needs per-bit states.
module mult_step_counter
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic inc,
   output logic last
);

   localparam int unsigned CNT_W = cnt_width(WIDTH);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign last = (cnt == CNT_W'(WIDTH - 1));

   cnt_bound: assert property (@(posedge clk) disable iff (reset) cnt <= CNT_W'(WIDTH - 1));

endmodule

// File: rtl/mult_seq_control.sv
// Control FSM for the sequential add-shift multiplier: CLEAR, then WIDTH add/shift pairs, then HOLD.
module mult_seq_control
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH  = 8,
   parameter bit          SIGNED = 1'b1
) (
   input  logic Clk,
   input  logic Reset,
   input  logic Run,
   input  logic ClearA_LoadB,
   input  logic M,
   output logic Ld_B,
   output logic Clr_XA,
   output logic Ld_XA,
   output logic Fn,
   output logic Shift_En,
   output logic Busy,
   output logic Done
);

   mult_state_t state, state_d;
   logic        cnt_clr, cnt_inc, last;

   mult_step_counter #(
      .WIDTH(WIDTH)
   ) u_step_counter (
      .clk  (Clk),
      .reset(Reset),
      .clr  (cnt_clr),
      .inc  (cnt_inc),
      .last (last)
   );

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   always_comb begin
      state_d  = state;
      cnt_clr  = 1'b0;
      cnt_inc  = 1'b0;
      Ld_B     = 1'b0;
      Clr_XA   = 1'b0;
      Ld_XA    = 1'b0;
      Fn       = FN_ADD;
      Shift_En = 1'b0;
      Busy     = 1'b0;
      Done     = 1'b0;
      case (state)
         IDLE: begin
            // Load/clear still acts in the cycle Run is accepted.
            Ld_B   = ClearA_LoadB;
            Clr_XA = ClearA_LoadB;
            if (Run) begin
               state_d = CLEAR;
               cnt_clr = 1'b1;
            end
         end
         CLEAR: begin
            Clr_XA  = 1'b1;
            Busy    = 1'b1;
            state_d = ADD;
         end
         ADD: begin
            Busy    = 1'b1;
            Ld_XA   = M;
            // Sign bit of a 2's-complement multiplier carries negative weight.
            Fn      = (SIGNED && last) ? FN_SUB : FN_ADD;
            state_d = SHIFT;
         end
         SHIFT: begin
            Busy     = 1'b1;
            Shift_En = 1'b1;
            if (last) begin
               state_d = HOLD;
            end else begin
               cnt_inc = 1'b1;
               state_d = ADD;
            end
         end
         HOLD: begin
            Done = 1'b1;
            if (!Run) begin
               state_d = IDLE;
               cnt_clr = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_clr = 1'b1;
         end
      endcase
   end

   no_load_and_shift: assert property (@(posedge Clk) disable iff (Reset) !(Ld_XA && Shift_En));
   busy_done_excl: assert property (@(posedge Clk) disable iff (Reset) !(Busy && Done));

endmodule
